// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Interlock and sequencing controller for the pipelined DLX core. Sits beside
//   the ID stage, keeps a shadow of the EX/MEM destinations and one in-flight
//   multi-cycle FPU op, and drives stall / bubble / flush / FPU handshake.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_id_*                  decoded register usage of the instruction in ID
//   i_ex_taken              branch/jump in EX is taken (flush has priority)
//   o_pc_stall/o_ifid_stall hold PC and IF/ID
//   o_idex_bubble           load a NOP into ID/EX
//   o_ifid_flush            clear IF/ID
//   o_fpu_start/busy/done   multi-cycle FPU handshake
//
// Build option
//   HAZARD_FWD_EN  defined   : bypass network present, only load-use and FPU
//                              conditions stall.
//                  undefined : any EX/MEM destination match also stalls.
module hazard_ctrl #(
    parameter int unsigned FPU_LAT = 5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_rs1_fp,
    input  logic       i_id_rs2_fp,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic [4:0] i_id_rd,
    input  logic       i_id_rd_fp,
    input  logic       i_id_regwe,
    input  logic       i_id_load,
    input  logic       i_id_fpu_multi,
    input  logic       i_ex_taken,
    output logic       o_pc_stall,
    output logic       o_ifid_stall,
    output logic       o_idex_bubble,
    output logic       o_ifid_flush,
    output logic       o_fpu_start,
    output logic       o_fpu_busy,
    output logic       o_fpu_done
);

    localparam logic [3:0] LAT_W = 4'(FPU_LAT);

    typedef struct packed {
        logic       valid;
        logic [5:0] dst;
        logic       regwe;
        logic       load;
    } slot_t;

    slot_t      r_ex;
    logic [3:0] r_fpu_cnt;
    logic [5:0] r_fpu_dst;

    logic [5:0] w_src1, w_src2, w_rd;
    logic       w_src1_live, w_src2_live, w_rd_live;
    logic       w_fpu_busy;
    logic       w_load_use, w_fpu_raw, w_fpu_waw, w_fpu_struct, w_slot_stall;
    logic       w_stall, w_issue, w_fpu_start;

    // GPR 0 is hard-wired: it can never create a dependency.
    assign w_src1      = {i_id_rs1_fp, i_id_rs1};
    assign w_src2      = {i_id_rs2_fp, i_id_rs2};
    assign w_rd        = {i_id_rd_fp, i_id_rd};
    assign w_src1_live = i_id_rs1_used & (w_src1 != 6'd0);
    assign w_src2_live = i_id_rs2_used & (w_src2 != 6'd0);
    assign w_rd_live   = i_id_regwe & (w_rd != 6'd0);

    function automatic logic f_hit(input logic s_valid, input logic s_regwe,
                                   input logic [5:0] s_dst,
                                   input logic [5:0] src, input logic live);
        return live & s_valid & s_regwe & (s_dst == src);
    endfunction

    assign w_fpu_busy   = (r_fpu_cnt != 4'd0);
    assign w_load_use   = r_ex.load &
                          (f_hit(r_ex.valid, r_ex.regwe, r_ex.dst, w_src1, w_src1_live) |
                           f_hit(r_ex.valid, r_ex.regwe, r_ex.dst, w_src2, w_src2_live));
    assign w_fpu_raw    = w_fpu_busy & ((w_src1_live & (w_src1 == r_fpu_dst)) |
                                        (w_src2_live & (w_src2 == r_fpu_dst)));
    assign w_fpu_waw    = w_fpu_busy & w_rd_live & (w_rd == r_fpu_dst);
    assign w_fpu_struct = w_fpu_busy & i_id_fpu_multi;

`ifdef HAZARD_FWD_EN
    assign w_slot_stall = 1'b0;
`else
    // Without bypassing the MEM destination is still pending in the register
    // file, so it is shadowed too; the load flag only matters in EX.
    logic       r_mem_valid, r_mem_regwe;
    logic [5:0] r_mem_dst;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_valid <= 1'b0;
            r_mem_regwe <= 1'b0;
            r_mem_dst   <= '0;
        end else begin
            r_mem_valid <= r_ex.valid;
            r_mem_regwe <= r_ex.regwe;
            r_mem_dst   <= r_ex.dst;
        end
    end

    assign w_slot_stall = f_hit(r_ex.valid, r_ex.regwe, r_ex.dst, w_src1, w_src1_live) |
                          f_hit(r_ex.valid, r_ex.regwe, r_ex.dst, w_src2, w_src2_live) |
                          f_hit(r_mem_valid, r_mem_regwe, r_mem_dst, w_src1, w_src1_live) |
                          f_hit(r_mem_valid, r_mem_regwe, r_mem_dst, w_src2, w_src2_live);
`endif

    // A taken transfer squashes ID, so it overrides any stall reason.
    assign w_stall     = i_id_valid & ~i_ex_taken &
                         (w_load_use | w_fpu_raw | w_fpu_waw | w_fpu_struct | w_slot_stall);
    assign w_issue     = i_id_valid & ~w_stall & ~i_ex_taken;
    assign w_fpu_start = w_issue & i_id_fpu_multi;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex <= '0;
        end else if (w_issue) begin
            r_ex <= '{valid: 1'b1, dst: w_rd, regwe: i_id_regwe, load: i_id_load};
        end else begin
            r_ex <= '0;
        end
    end

    // Busy down-counter; a flush never cancels it because the op is older.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fpu_cnt <= 4'd0;
            r_fpu_dst <= '0;
        end else if (w_fpu_start) begin
            r_fpu_cnt <= LAT_W;
            r_fpu_dst <= w_rd;
        end else if (w_fpu_busy) begin
            r_fpu_cnt <= r_fpu_cnt - 4'd1;
        end
    end

    // Outputs are held low during reset regardless of the ID inputs.
    assign o_pc_stall    = i_rst_n & w_stall;
    assign o_ifid_stall  = i_rst_n & w_stall;
    assign o_idex_bubble = i_rst_n & (w_stall | i_ex_taken);
    assign o_ifid_flush  = i_rst_n & i_ex_taken;
    assign o_fpu_start   = i_rst_n & w_fpu_start;
    assign o_fpu_busy    = i_rst_n & w_fpu_busy;
    assign o_fpu_done    = i_rst_n & (r_fpu_cnt == 4'd1);

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int LAT = 5;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic       valid;
        logic [5:0] s1;
        logic       u1;
        logic [5:0] s2;
        logic       u2;
        logic [5:0] d;
        logic       regwe;
        logic       load;
        logic       multi;
    } instr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic taken = 1'b0;
    instr_t cur = '0;
    logic pc_stall, ifid_stall, idex_bubble, ifid_flush, fpu_start, fpu_busy, fpu_done;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: which instruction issued in which cycle, plus the
    // issue cycle of the latest multi-cycle FPU op.
    int         cyc = 0;
    instr_t     issued [int];
    int         fpu_t = -1000;
    logic [5:0] fpu_dst = '0;
    logic       exp_stall_last = 1'b0;
    logic       obs_stall, obs_flush, obs_bubble, obs_start, obs_busy;

    always #5 clk = ~clk;

    hazard_ctrl #(.FPU_LAT(LAT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_id_valid     (cur.valid),
        .i_id_rs1       (cur.s1[4:0]),
        .i_id_rs2       (cur.s2[4:0]),
        .i_id_rs1_fp    (cur.s1[5]),
        .i_id_rs2_fp    (cur.s2[5]),
        .i_id_rs1_used  (cur.u1),
        .i_id_rs2_used  (cur.u2),
        .i_id_rd        (cur.d[4:0]),
        .i_id_rd_fp     (cur.d[5]),
        .i_id_regwe     (cur.regwe),
        .i_id_load      (cur.load),
        .i_id_fpu_multi (cur.multi),
        .i_ex_taken     (taken),
        .o_pc_stall     (pc_stall),
        .o_ifid_stall   (ifid_stall),
        .o_idex_bubble  (idex_bubble),
        .o_ifid_flush   (ifid_flush),
        .o_fpu_start    (fpu_start),
        .o_fpu_busy     (fpu_busy),
        .o_fpu_done     (fpu_done)
    );

    function automatic logic [5:0] gpr(input int n);
        return {1'b0, 5'(n)};
    endfunction

    function automatic logic [5:0] fpr(input int n);
        return {1'b1, 5'(n)};
    endfunction

    function automatic instr_t mk(input logic [5:0] d, input logic [5:0] s1, input logic [5:0] s2,
                                  input logic u2, input logic load, input logic multi);
        instr_t r;
        r = '{valid: 1'b1, s1: s1, u1: 1'b1, s2: s2, u2: u2, d: d,
              regwe: 1'b1, load: load, multi: multi};
        return r;
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        r.valid = ($urandom_range(0, 7) != 0);
        r.multi = ($urandom_range(0, 5) == 0);
        r.load  = !r.multi && ($urandom_range(0, 3) == 0);
        r.s1    = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
        r.s2    = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
        r.u1    = ($urandom_range(0, 3) != 0);
        r.u2    = ($urandom_range(0, 3) != 0);
        r.d     = {r.multi ? 1'b1 : 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
        r.regwe = r.multi || r.load || ($urandom_range(0, 3) != 0);
        return r;
    endfunction

    // Source reads destination of e (GPR 0 never counts).
    function automatic logic dep(input instr_t e, input logic [5:0] src, input logic used);
        return used && (src != 6'd0) && e.valid && e.regwe && (e.d == src);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: compare all outputs at the falling edge, advance the model at
    // the rising edge, return 1 ns after it.
    task automatic step();
        instr_t ex, mem;
        logic busy, done, lu, raw, waw, st, gen, stl, iss;
        @(negedge clk);
        ex   = issued.exists(cyc - 1) ? issued[cyc - 1] : '0;
        mem  = issued.exists(cyc - 2) ? issued[cyc - 2] : '0;
        busy = (cyc > fpu_t) && (cyc <= fpu_t + LAT);
        done = (cyc == fpu_t + LAT);
        lu   = ex.load && (dep(ex, cur.s1, cur.u1) || dep(ex, cur.s2, cur.u2));
        raw  = busy && ((cur.u1 && cur.s1 != 0 && cur.s1 == fpu_dst) ||
                        (cur.u2 && cur.s2 != 0 && cur.s2 == fpu_dst));
        waw  = busy && cur.regwe && cur.d != 0 && cur.d == fpu_dst;
        st   = busy && cur.multi;
        gen  = !FWD && (dep(ex, cur.s1, cur.u1) || dep(ex, cur.s2, cur.u2) ||
                        dep(mem, cur.s1, cur.u1) || dep(mem, cur.s2, cur.u2));
        stl  = rst_n && cur.valid && !taken && (lu || raw || waw || st || gen);
        iss  = rst_n && cur.valid && !taken && !stl;
        check("pc_stall",    pc_stall,    stl);
        check("ifid_stall",  ifid_stall,  stl);
        check("idex_bubble", idex_bubble, rst_n && (stl || taken));
        check("ifid_flush",  ifid_flush,  rst_n && taken);
        check("fpu_start",   fpu_start,   iss && cur.multi);
        check("fpu_busy",    fpu_busy,    rst_n && busy);
        check("fpu_done",    fpu_done,    rst_n && done);
        obs_stall  = pc_stall;
        obs_flush  = ifid_flush;
        obs_bubble = idex_bubble;
        obs_start  = fpu_start;
        obs_busy   = fpu_busy;
        exp_stall_last = stl;
        @(posedge clk);
        if (!rst_n) begin
            issued.delete();
            fpu_t = -1000;
        end else if (iss) begin
            issued[cyc] = cur;
            if (cur.multi) begin
                fpu_t   = cyc;
                fpu_dst = cur.d;
            end
        end
        cyc++;
        #1;
    endtask

    // Hold the current instruction until it issues; count its stall cycles.
    task automatic until_issue(input string tag, input int exp);
        int n;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!obs_stall) break;
            n++;
        end
        check(tag, n, exp);
        cur = '0;
    endtask

    task automatic drain();
        cur   = '0;
        taken = 1'b0;
        repeat (LAT + 3) step();
    endtask

    initial begin
        // Reset: outputs forced low whatever ID presents.
        repeat (2) begin
            cur       = rand_instr();
            cur.valid = 1'b1;
            taken     = 1'($urandom_range(0, 1));
            step();
        end
        rst_n = 1'b1;
        drain();

        // Load-use, and load into r0.
        cur = mk(gpr(3), gpr(1), gpr(0), 1'b0, 1'b1, 1'b0);
        step();
        cur = mk(gpr(4), gpr(3), gpr(5), 1'b1, 1'b0, 1'b0);
        until_issue("load_use_stalls", FWD ? 1 : 2);
        drain();
        cur = mk(gpr(0), gpr(1), gpr(0), 1'b0, 1'b1, 1'b0);
        step();
        cur = mk(gpr(4), gpr(0), gpr(5), 1'b1, 1'b0, 1'b0);
        until_issue("load_r0_stalls", 0);
        drain();

        // FPU RAW.
        cur = mk(fpr(2), fpr(0), fpr(1), 1'b1, 1'b0, 1'b1);
        step();
        check("fpu_start_issue", obs_start, 1);
        cur = mk(fpr(4), fpr(2), fpr(6), 1'b1, 1'b0, 1'b0);
        until_issue("fpu_raw_stalls", LAT);
        drain();

        // FPU structural, then an independent op behind a DIVF.
        cur = mk(fpr(10), fpr(1), fpr(3), 1'b1, 1'b0, 1'b1);
        step();
        cur = mk(fpr(12), fpr(5), fpr(7), 1'b1, 1'b0, 1'b1);
        until_issue("fpu_struct_stalls", LAT);
        drain();
        cur = mk(fpr(10), fpr(1), fpr(3), 1'b1, 1'b0, 1'b1);
        step();
        cur = mk(fpr(8), fpr(1), fpr(3), 1'b1, 1'b0, 1'b0);
        until_issue("fpu_indep_stalls", 0);
        drain();

        // Flush beats a pending load-use stall.
        cur = mk(gpr(3), gpr(1), gpr(0), 1'b0, 1'b1, 1'b0);
        step();
        cur   = mk(gpr(4), gpr(3), gpr(5), 1'b1, 1'b0, 1'b0);
        taken = 1'b1;
        step();
        check("flush_ifid_flush", obs_flush, 1);
        check("flush_bubble", obs_bubble, 1);
        check("flush_pc_stall", obs_stall, 0);
        taken = 1'b0;
        cur   = mk(gpr(6), gpr(3), gpr(7), 1'b1, 1'b0, 1'b0);
        until_issue("post_flush_stalls", FWD ? 0 : 1);
        drain();

        // Plain RAW, adjacent and one apart.
        cur = mk(gpr(1), gpr(2), gpr(5), 1'b1, 1'b0, 1'b0);
        step();
        cur = mk(gpr(2), gpr(1), gpr(5), 1'b1, 1'b0, 1'b0);
        until_issue("raw_adjacent_stalls", FWD ? 0 : 2);
        drain();
        cur = mk(gpr(1), gpr(2), gpr(5), 1'b1, 1'b0, 1'b0);
        step();
        cur = '0;
        step();
        cur = mk(gpr(2), gpr(1), gpr(5), 1'b1, 1'b0, 1'b0);
        until_issue("raw_gap_stalls", FWD ? 0 : 1);
        drain();

        // Reset during busy cycle 2, then a MULTF right after release.
        cur = mk(fpr(2), fpr(0), fpr(1), 1'b1, 1'b0, 1'b1);
        step();
        cur = '0;
        step();
        #1;
        rst_n     = 1'b0;
        cur       = rand_instr();
        cur.valid = 1'b1;
        taken     = 1'($urandom_range(0, 1));
        step();
        check("reset_fpu_busy", obs_busy, 0);
        step();
        rst_n = 1'b1;
        taken = 1'b0;
        cur   = mk(fpr(3), fpr(1), fpr(2), 1'b1, 1'b0, 1'b1);
        step();
        check("post_reset_start", obs_start, 1);
        drain();

        // Random traffic; a stalled instruction stays in ID until it issues.
        cur = '0;
        exp_stall_last = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!exp_stall_last) cur = rand_instr();
            taken = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
